// File: rtl/touch_adc_pkg.sv
// Shared types and constants for the touch-screen ADC responder.
package touch_adc_pkg;

   typedef enum logic [2:0] {IDLE, CMD, WAIT, CONV, DATA} state_e;

   // Control byte layout {S, A2, A1, A0, MODE, SER/DFR, PD1, PD0}
   localparam int unsigned BIT_S    = 7;
   localparam int unsigned BIT_A2   = 6;
   localparam int unsigned BIT_A0   = 4;
   localparam int unsigned BIT_MODE = 3;

   localparam int unsigned DATA_W  = 12;
   localparam int unsigned DATA_W8 = 8;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchronizer with registered rise/fall strobes on d_i; aux_i shares
// the same chain so it stays cycle-aligned with the edge signal.
module sync_edge_det #(
   parameter int unsigned STAGES = 2,
   parameter int unsigned AUX_W  = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             d_i,
   input  logic [AUX_W-1:0] aux_i,
   output logic [AUX_W-1:0] aux_o,
   output logic             rise_o,
   output logic             fall_o
);

   localparam int unsigned W = AUX_W + 1;

   logic [W-1:0] stage_q [STAGES];
   logic         prev_q;
   logic         rise_q;
   logic         fall_q;
   logic         d_sync;

   assign d_sync = stage_q[STAGES-1][0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         stage_q[0] <= {aux_i, d_i};
         for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
         prev_q <= d_sync;
         rise_q <= d_sync & ~prev_q;
         fall_q <= ~d_sync & prev_q;
      end
   end

   assign aux_o  = stage_q[STAGES-1][W-1:1];
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/touch_adc_responder.sv
// Peripheral end of the 4-wire touch ADC serial link: decodes the control byte on
// DCLK rises and returns a held X/Y sample MSB first on DCLK falls.
module touch_adc_responder
   import touch_adc_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [2:0]  CH_X_CODE   = 3'b101,
   parameter logic [2:0]  CH_Y_CODE   = 3'b001
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ADC_DCLK,
   input  logic        ADC_CS,
   input  logic        ADC_DIN,
   input  logic        PEN_DOWN,
   input  logic [11:0] X_VALUE,
   input  logic [11:0] Y_VALUE,
   output logic        ADC_DOUT,
   output logic        ADC_BUSY,
   output logic        ADC_PENIRQ_n,
   output logic        CMD_VALID,
   output logic [7:0]  CMD_BYTE
);

   logic cs_s, din_s, dclk_rise, dclk_fall;

   sync_edge_det #(
      .STAGES (SYNC_STAGES),
      .AUX_W  (2)
   ) u_sync (
      .clk_i  (CLK),
      .rst_i  (RST),
      .d_i    (ADC_DCLK),
      .aux_i  ({ADC_DIN, ADC_CS}),
      .aux_o  ({din_s, cs_s}),
      .rise_o (dclk_rise),
      .fall_o (dclk_fall)
   );

   state_e      state_q, state_d;
   logic [2:0]  cmd_cnt_q, cmd_cnt_d;
   logic [3:0]  data_cnt_q, data_cnt_d;
   logic [7:0]  cmd_sr_q, cmd_sr_d;
   logic [11:0] sample_q, sample_d;
   logic        mode8_q, mode8_d;
   logic        dout_q, dout_d;
   logic        busy_q, busy_d;
   logic        penirq_q, penirq_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [7:0]  cmd_byte_q, cmd_byte_d;

   logic [7:0]  new_byte;
   logic [2:0]  chan;
   logic [11:0] sel_sample;
   logic [3:0]  last_bit;

   assign new_byte   = {cmd_sr_q[6:0], din_s};
   assign chan       = new_byte[BIT_A2:BIT_A0];
   assign sel_sample = (chan == CH_X_CODE) ? X_VALUE :
                       (chan == CH_Y_CODE) ? Y_VALUE : 12'h000;
   assign last_bit   = mode8_q ? 4'(DATA_W8) : 4'(DATA_W);

   always_comb begin
      state_d     = state_q;
      cmd_cnt_d   = cmd_cnt_q;
      data_cnt_d  = data_cnt_q;
      cmd_sr_d    = cmd_sr_q;
      sample_d    = sample_q;
      mode8_d     = mode8_q;
      dout_d      = dout_q;
      busy_d      = busy_q;
      cmd_valid_d = 1'b0;
      cmd_byte_d  = cmd_byte_q;
      penirq_d    = (state_q == IDLE && cs_s) ? ~PEN_DOWN : 1'b1;

      if (cs_s) begin
         // Deselect aborts whatever is in flight; CMD_BYTE is kept.
         state_d = IDLE;
         busy_d  = 1'b0;
         dout_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (dclk_rise && din_s) begin
                  state_d   = CMD;
                  cmd_cnt_d = 3'd1;
                  cmd_sr_d  = 8'h01;
               end
            end
            CMD: begin
               if (dclk_rise) begin
                  cmd_sr_d  = new_byte;
                  cmd_cnt_d = cmd_cnt_q + 3'd1;
                  if (cmd_cnt_q == 3'd7) begin
                     cmd_byte_d  = new_byte;
                     cmd_valid_d = 1'b1;
                     mode8_d     = new_byte[BIT_MODE];
                     // 8-bit mode keeps the top byte, left-aligned for MSB-first shifting.
                     sample_d    = new_byte[BIT_MODE] ? {sel_sample[11:4], 4'h0} : sel_sample;
                     state_d     = WAIT;
                  end
               end
            end
            WAIT: begin
               if (dclk_fall) begin
                  busy_d  = 1'b1;
                  state_d = CONV;
               end
            end
            CONV: begin
               if (dclk_fall) begin
                  busy_d     = 1'b0;
                  dout_d     = sample_q[11];
                  sample_d   = {sample_q[10:0], 1'b0};
                  data_cnt_d = 4'd1;
                  state_d    = DATA;
               end
            end
            DATA: begin
               if (dclk_fall) begin
                  if (data_cnt_q == last_bit) begin
                     dout_d  = 1'b0;
                     state_d = IDLE;
                  end else begin
                     dout_d     = sample_q[11];
                     sample_d   = {sample_q[10:0], 1'b0};
                     data_cnt_d = data_cnt_q + 4'd1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         cmd_cnt_q   <= '0;
         data_cnt_q  <= '0;
         cmd_sr_q    <= '0;
         sample_q    <= '0;
         mode8_q     <= 1'b0;
         dout_q      <= 1'b0;
         busy_q      <= 1'b0;
         penirq_q    <= 1'b1;
         cmd_valid_q <= 1'b0;
         cmd_byte_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         cmd_cnt_q   <= cmd_cnt_d;
         data_cnt_q  <= data_cnt_d;
         cmd_sr_q    <= cmd_sr_d;
         sample_q    <= sample_d;
         mode8_q     <= mode8_d;
         dout_q      <= dout_d;
         busy_q      <= busy_d;
         penirq_q    <= penirq_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_byte_q  <= cmd_byte_d;
      end
   end

   assign ADC_DOUT     = dout_q;
   assign ADC_BUSY     = busy_q;
   assign ADC_PENIRQ_n = penirq_q;
   assign CMD_VALID    = cmd_valid_q;
   assign CMD_BYTE     = cmd_byte_q;

endmodule

// File: tb/tb_touch_adc_responder.sv
// Bench for touch_adc_responder: acts as the ADC controller, driving DCLK/CS/DIN and
// sampling DOUT/BUSY just before each DCLK rise.
module tb_touch_adc_responder;

   localparam int H = 10;  // CLK cycles per DCLK phase

   logic        CLK = 1'b0;
   logic        RST;
   logic        ADC_DCLK, ADC_CS, ADC_DIN, PEN_DOWN;
   logic [11:0] X_VALUE, Y_VALUE;
   logic        ADC_DOUT, ADC_BUSY, ADC_PENIRQ_n, CMD_VALID;
   logic [7:0]  CMD_BYTE;

   touch_adc_responder dut (
      .CLK          (CLK),
      .RST          (RST),
      .ADC_DCLK     (ADC_DCLK),
      .ADC_CS       (ADC_CS),
      .ADC_DIN      (ADC_DIN),
      .PEN_DOWN     (PEN_DOWN),
      .X_VALUE      (X_VALUE),
      .Y_VALUE      (Y_VALUE),
      .ADC_DOUT     (ADC_DOUT),
      .ADC_BUSY     (ADC_BUSY),
      .ADC_PENIRQ_n (ADC_PENIRQ_n),
      .CMD_VALID    (CMD_VALID),
      .CMD_BYTE     (CMD_BYTE)
   );

   always #5 CLK = ~CLK;

   int compared   = 0;
   int mismatched = 0;
   int cv_cnt     = 0;

   always @(posedge CLK) if (CMD_VALID === 1'b1) cv_cnt++;

   typedef struct {
      logic [7:0]  b;
      int          zeros;
      logic [11:0] x0, y0, x1, y1;
      logic [11:0] exp_val;
      int          exp_len;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic dclk_cycle(input logic din_v, output logic busy_s, output logic dout_s,
                             output logic pen_s);
      ADC_DIN = din_v;
      repeat (H) @(posedge CLK);
      #1;
      busy_s   = ADC_BUSY;
      dout_s   = ADC_DOUT;
      pen_s    = ADC_PENIRQ_n;
      ADC_DCLK = 1'b1;
      repeat (H) @(posedge CLK);
      #1 ADC_DCLK = 1'b0;
   endtask

   // Reference: channel decode and width selection straight from the command byte.
   function automatic void ref_model(input logic [7:0] b, input logic [11:0] x,
                                     input logic [11:0] y, output logic [11:0] v,
                                     output int len);
      int ch;
      int full;
      ch   = (int'(b) / 16) % 8;
      full = (ch == 5) ? int'(x) : (ch == 1) ? int'(y) : 0;
      if ((int'(b) / 8) % 2 == 1) begin
         len = 8;
         v   = 12'(full / 16);
      end else begin
         len = 12;
         v   = 12'(full);
      end
   endfunction

   task automatic frame(input string name, input logic [7:0] b, input int zeros,
                        input logic [11:0] x0, input logic [11:0] y0,
                        input logic [11:0] x1, input logic [11:0] y1,
                        input logic [11:0] exp_val, input int exp_len);
      logic        bs, ds, ps;
      logic [11:0] got;
      int          pen_bad, busy_bad;
      got      = '0;
      pen_bad  = 0;
      busy_bad = 0;
      X_VALUE  = x0;
      Y_VALUE  = y0;
      cv_cnt   = 0;
      ADC_CS   = 1'b0;
      repeat (H) @(posedge CLK);
      #1;
      for (int i = 0; i < zeros; i++) begin
         dclk_cycle(1'b0, bs, ds, ps);
         if (ps !== 1'b1) pen_bad++;
         if (bs !== 1'b0) busy_bad++;
      end
      for (int i = 7; i >= 0; i--) begin
         dclk_cycle(b[i], bs, ds, ps);
         if (ps !== 1'b1) pen_bad++;
         if (bs !== 1'b0) busy_bad++;
      end
      X_VALUE = x1;
      Y_VALUE = y1;
      dclk_cycle(1'($urandom), bs, ds, ps);
      if (ps !== 1'b1) pen_bad++;
      check({name, "_busy_hi"}, 32'(bs), 32'd1);
      check({name, "_dout_busy"}, 32'(ds), 32'd0);
      for (int i = 0; i < exp_len; i++) begin
         dclk_cycle(1'($urandom), bs, ds, ps);
         got = {got[10:0], ds};
         if (ps !== 1'b1) pen_bad++;
         if (bs !== 1'b0) busy_bad++;
      end
      dclk_cycle(1'b0, bs, ds, ps);
      if (ps !== 1'b1) pen_bad++;
      check({name, "_trail_dout"}, 32'(ds), 32'd0);
      check({name, "_trail_busy"}, 32'(bs), 32'd0);
      check({name, "_data"}, 32'(got), 32'(exp_val));
      ADC_CS  = 1'b1;
      ADC_DIN = 1'b0;
      repeat (H) @(posedge CLK);
      #1;
      check({name, "_cmd_valid_cycles"}, 32'(cv_cnt), 32'd1);
      check({name, "_cmd_byte"}, 32'(CMD_BYTE), 32'(b));
      check({name, "_busy_only_once"}, 32'(busy_bad), 32'd0);
      check({name, "_penirq_in_frame"}, 32'(pen_bad), 32'd0);
      check({name, "_penirq_after"}, 32'(ADC_PENIRQ_n), 32'(!PEN_DOWN));
   endtask

   initial begin
      logic        bs, ds, ps;
      logic [7:0]  rb;
      logic [11:0] rx0, ry0, rx1, ry1, ev;
      int          el;

      vecs[0] = '{b: 8'hD0, zeros: 0, x0: 12'hA5C, y0: 12'h123, x1: 12'hA5C, y1: 12'h123,
                  exp_val: 12'hA5C, exp_len: 12};
      vecs[1] = '{b: 8'h98, zeros: 0, x0: 12'h456, y0: 12'h3F1, x1: 12'h456, y1: 12'h3F1,
                  exp_val: 12'h03F, exp_len: 8};
      vecs[2] = '{b: 8'h90, zeros: 2, x0: 12'h777, y0: 12'h800, x1: 12'h777, y1: 12'h001,
                  exp_val: 12'h800, exp_len: 12};
      vecs[3] = '{b: 8'hD8, zeros: 0, x0: 12'hA5C, y0: 12'h000, x1: 12'hFFF, y1: 12'hFFF,
                  exp_val: 12'h0A5, exp_len: 8};
      vecs[4] = '{b: 8'hA0, zeros: 1, x0: 12'hFFF, y0: 12'hFFF, x1: 12'hFFF, y1: 12'hFFF,
                  exp_val: 12'h000, exp_len: 12};
      vecs[5] = '{b: 8'h94, zeros: 0, x0: 12'h0F0, y0: 12'h5A5, x1: 12'h0F0, y1: 12'h5A5,
                  exp_val: 12'h5A5, exp_len: 12};

      RST      = 1'b1;
      ADC_DCLK = 1'b0;
      ADC_CS   = 1'b1;
      ADC_DIN  = 1'b0;
      PEN_DOWN = 1'b0;
      X_VALUE  = '0;
      Y_VALUE  = '0;
      repeat (3) @(posedge CLK);
      #1;
      check("reset_dout", 32'(ADC_DOUT), 32'd0);
      check("reset_busy", 32'(ADC_BUSY), 32'd0);
      check("reset_penirq", 32'(ADC_PENIRQ_n), 32'd1);
      check("reset_cmd_valid", 32'(CMD_VALID), 32'd0);
      check("reset_cmd_byte", 32'(CMD_BYTE), 32'h00);
      RST = 1'b0;

      // Pen interrupt follows PEN_DOWN one CLK later while idle and deselected.
      repeat (5) @(posedge CLK);
      #1;
      check("pen_up_idle", 32'(ADC_PENIRQ_n), 32'd1);
      PEN_DOWN = 1'b1;
      @(posedge CLK);
      #1;
      check("pen_latency", 32'(ADC_PENIRQ_n), 32'd0);

      foreach (vecs[i])
         frame($sformatf("vec%0d", i), vecs[i].b, vecs[i].zeros, vecs[i].x0, vecs[i].y0,
               vecs[i].x1, vecs[i].y1, vecs[i].exp_val, vecs[i].exp_len);

      // Partial command: five bits of 8'hD0 then deselect.
      cv_cnt = 0;
      ADC_CS = 1'b0;
      repeat (H) @(posedge CLK);
      #1;
      for (int i = 7; i >= 3; i--) begin
         rb = 8'hD0;
         dclk_cycle(rb[i], bs, ds, ps);
      end
      ADC_CS = 1'b1;
      for (int i = 0; i < 3; i++) dclk_cycle(1'b1, bs, ds, ps);
      check("abort_busy", 32'(bs), 32'd0);
      check("abort_cmd_valid", 32'(cv_cnt), 32'd0);
      check("abort_cmd_byte_kept", 32'(CMD_BYTE), 32'h94);
      frame("after_abort", 8'hD0, 0, 12'hA5C, 12'h000, 12'hA5C, 12'h000, 12'hA5C, 12);

      for (int n = 0; n < 16; n++) begin
         rb = 8'($urandom);
         case ($urandom_range(0, 2))
            0: rb[6:4] = 3'b101;
            1: rb[6:4] = 3'b001;
            default: ;
         endcase
         rb[7]    = 1'b1;
         rx0      = 12'($urandom);
         ry0      = 12'($urandom);
         rx1      = 12'($urandom);
         ry1      = 12'($urandom);
         PEN_DOWN = 1'($urandom);
         ref_model(rb, rx0, ry0, ev, el);
         frame($sformatf("rnd%0d_%02h", n, rb), rb, $urandom_range(0, 2), rx0, ry0, rx1, ry1,
               ev, el);
      end

      // Reset in the middle of the data phase while DOUT is high.
      PEN_DOWN = 1'b1;
      X_VALUE  = 12'hA5C;
      ADC_CS   = 1'b0;
      repeat (H) @(posedge CLK);
      #1;
      for (int i = 7; i >= 0; i--) begin
         rb = 8'hD0;
         dclk_cycle(rb[i], bs, ds, ps);
      end
      dclk_cycle(1'b0, bs, ds, ps);
      dclk_cycle(1'b0, bs, ds, ps);
      dclk_cycle(1'b0, bs, ds, ps);
      repeat (H) @(posedge CLK);
      #1;
      check("pre_reset_dout", 32'(ADC_DOUT), 32'd1);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      check("midreset_dout", 32'(ADC_DOUT), 32'd0);
      check("midreset_busy", 32'(ADC_BUSY), 32'd0);
      check("midreset_penirq", 32'(ADC_PENIRQ_n), 32'd1);
      check("midreset_cmd_byte", 32'(CMD_BYTE), 32'h00);
      RST    = 1'b0;
      ADC_CS = 1'b1;
      repeat (H) @(posedge CLK);
      #1;
      frame("after_reset", 8'h98, 0, 12'h000, 12'h3F1, 12'h000, 12'h3F1, 12'h03F, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/touch_adc_responder.md
# touch_adc_responder

Synthesizable responder for the 4-wire touch-screen ADC serial link: the peripheral end of the protocol that the ADC controller drives. It oversamples the controller's ADC_DCLK/ADC_CS/ADC_DIN, decodes the 8-bit control byte, and asserts ADC_BUSY. It then shifts a 12-bit (or 8-bit) sample from programmable X/Y registers out on ADC_DOUT and drives ADC_PENIRQ_n from a pen-down stimulus. Used for board-level loopback and as the bus-functional model in controller regressions.

## Interface
- SYNC_STAGES, 2, synchronizer depth on ADC_DCLK, ADC_CS, ADC_DIN (≥2)
- CH_X_CODE, 3'b101, A2..A0 value selecting X_VALUE
- CH_Y_CODE, 3'b001, A2..A0 value selecting Y_VALUE

Ports:
- CLK  in  1  system clock; sole clock domain
- RST  in  1  synchronous, active-high reset
- ADC_DCLK  in  1  serial clock from controller, asynchronous to CLK
- ADC_CS  in  1  chip select from controller, active low
- ADC_DIN  in  1  command bit stream, MSB first
- PEN_DOWN  in  1  touch stimulus, 1 = touched
- X_VALUE  in  12  X sample returned for CH_X_CODE
- Y_VALUE  in  12  Y sample returned for CH_Y_CODE
- ADC_DOUT  out  1  serial data to controller, MSB first
- ADC_BUSY  out  1  conversion-in-progress flag
- ADC_PENIRQ_n  out  1  pen interrupt, active low
- CMD_VALID  out  1  one-CLK pulse when a full control byte has been received
- CMD_BYTE  out  8  last received control byte {S,A2,A1,A0,MODE,SER/DFR,PD1,PD0}

## Operation
- All inputs pass through SYNC_STAGES flops. A registered edge detector on synced DCLK yields rise/fall strobes; all state changes occur only on strobes.
- States:
  - IDLE: on rise with CS low and DIN=1 (start bit) → CMD, bit count=1, shift register={7'b0,1}. Rises with DIN=0 are ignored.
  - CMD: each rise shifts DIN in. On the 8th bit:
    - CMD_BYTE ← byte and CMD_VALID pulses.
    - Sample latched: X_VALUE if A2..A0=CH_X_CODE, Y_VALUE if =CH_Y_CODE, else 12'h000. MODE=1 keeps only sample[11:4].
    - → WAIT.
  - WAIT: next fall → BUSY=1 → CONV.
  - CONV: next fall → BUSY=0, DOUT=sample MSB, → DATA with bit count=1.
  - DATA: each fall drives the next bit. The fall after the last bit (12th, or 8th in MODE=1) drives DOUT=0 → IDLE.
- Sample-and-hold: X_VALUE/Y_VALUE changes after the latch do not affect the frame in flight.
- CS synced high in any state: → IDLE next CLK, BUSY=0, DOUT=0. CMD_BYTE retains its value. A partial byte never pulses CMD_VALID.
- A start bit is only recognised in IDLE. DIN during WAIT/CONV/DATA is ignored, so there is no command overlap.
- PENIRQ_n = ~PEN_DOWN (registered) in IDLE with CS high. Forced high whenever state≠IDLE or CS is low.
- Reset values: ADC_DOUT=0, ADC_BUSY=0, ADC_PENIRQ_n=1, CMD_VALID=0, CMD_BYTE=8'h00, state IDLE. Reset mid-frame aborts the frame with the same values.

## Timing
- Latency: ADC_DCLK pin edge to output change is SYNC_STAGES+2 CLK cycles, fixed.
- ADC_DCLK high and low phases must each be ≥ SYNC_STAGES+4 CLK cycles. At 50 MHz/70 kHz there are ~357 cycles per phase.
- Controller samples DOUT/BUSY on DCLK rise. The responder changes them only on fall strobes, giving half a DCLK period of setup.
- CMD_VALID is exactly 1 CLK wide, in the cycle after the 8th rise strobe.
- PEN_DOWN to PENIRQ_n latency is 1 CLK (unsynchronised; PEN_DOWN is CLK-domain stimulus).
- Frame = 8 rises (command) + 1 busy fall + 12 data falls (8 in MODE=1) + 1 trailing fall.

## Structure
- Package touch_adc_pkg holds:
  - state enum {IDLE, CMD, WAIT, CONV, DATA}
  - control-byte bit index constants (S=7, A2..A0=6:4, MODE=3)
  - DATA_W=12 and DATA_W8=8
- Sub-module sync_edge_det holds an SYNC_STAGES-deep synchronizer plus registered rise/fall strobes. It is instantiated for DCLK; CS and DIN use its synced output only.
- Top holds the FSM, 3-bit command counter, 4-bit data counter, and the 8-bit and 12-bit shift registers.

## Test plan
- Reset mid-DATA with X_VALUE=12'hA5C → next CLK DOUT=0, BUSY=0, PENIRQ_n=1, CMD_BYTE=8'h00.
- CS low, byte 8'hD0, X_VALUE=12'hA5C → CMD_VALID once, CMD_BYTE=8'hD0, BUSY high for exactly one DCLK period, DOUT bits 1010_0101_1100 on successive falls, then 0.
- Byte 8'h98 (MODE=1, Y), Y_VALUE=12'h3F1 → 8 data bits 0011_1111, then DOUT=0 and IDLE.
- Two leading zeros then 8'h90, Y_VALUE=12'h800 changed to 12'h001 during BUSY → zeros ignored, 1000_0000_0000 shifted out (held value).
- CS raised after 5 command bits → no CMD_VALID, BUSY stays 0. A fresh 8'hD0 frame then completes normally.
- PEN_DOWN=1 with CS high → PENIRQ_n=0 after 1 CLK. CS low → PENIRQ_n=1 for the whole frame, returning to 0 after CS high.
